seg7_reader: RTL and testbench
==============================

Name: seg7_reader

Overview:
- Receive side of the 7-segment output bus: samples a raw segment pattern, for example one looped back from a display driver or arriving from another board.
- Synchronises and debounces the pattern, then classifies it as a hex digit, a single-segment chase step (segments a..f rotating) or blank.
- Checks that chase steps arrive in order and counts protocol errors.
- Sits between a board-level segment bus and the self-check/status logic of a lab design.

Parameters:
- ACTIVE_LOW, 1, 1 = segment lit when bit is 0 (common anode); 0 = lit when 1 (common cathode).
- STABLE_CYCLES, 3, consecutive identical synchronised samples required before a pattern is accepted; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- seg_in  input  7  raw segment bus, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; asynchronous to clk
- pattern_out  output  7  last accepted pattern, normalised to active-high (1 = lit)
- new_pattern  output  1  one-cycle pulse when pattern_out changes
- digit_valid  output  1  pattern_out is a legal hex glyph
- digit_out  output  4  decoded hex value; 0 when digit_valid=0
- chase_valid  output  1  pattern_out has exactly one of bits 6..1 set and bit0 clear
- chase_pos  output  3  chase position 0..5 (bit6 -> 0 ... bit1 -> 5); 0 when chase_valid=0
- err_count  output  8  saturating count of illegal patterns and out-of-order chase steps

Behaviour:
- Interface: one clock domain (clk); reset is asynchronous and active-high. All flops clear on reset assertion, independent of clk.
- Reset values:
  - Sync stages and candidate register: blank value in raw polarity (7'h7F if ACTIVE_LOW, else 7'h00).
  - pattern_out = 0, new_pattern = 0, digit_valid = 0, digit_out = 0, chase_valid = 0, chase_pos = 0, err_count = 0.
  - Stability counter = 0; chase history flag = 0.
- Normalisation: norm = ACTIVE_LOW ? ~sync2 : sync2. All classification uses norm.
- Synchroniser: 2 flops (sync1, sync2). No logic between them.
- Stability filter:
  - Each edge, if norm != cand then cand <= norm and cnt <= 1; else if cnt < STABLE_CYCLES then cnt <= cnt + 1.
  - A pattern is accepted on the edge where cnt would reach STABLE_CYCLES and cand (or norm when STABLE_CYCLES = 1) differs from pattern_out.
  - No re-accept while the same pattern persists.
- Latency: seg_in settled before edge 1 -> outputs and new_pattern update at edge 2+STABLE_CYCLES.
- Glitch rejection: a change shorter than STABLE_CYCLES synchronised samples produces no new_pattern.
- Accept actions, all on the same edge:
  - Load pattern_out; pulse new_pattern for exactly one cycle.
  - Register the digit and chase classifications.
- Digit table, active-high {a..g}: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
- Classes are mutually exclusive:
  - blank = 00; neither valid flag set; no error.
  - Any pattern that is not blank, not a digit and not a chase step is illegal. This includes g alone (01). Result: err_count + 1, both valid flags 0.
- Chase sequencing:
  - A chase step with the history flag set and pos != (prev_pos + 1) mod 6 -> err_count + 1. Outputs still update to the new position.
  - Any accepted chase step sets the history flag and stores prev_pos.
  - Any accepted non-chase pattern (digit, blank or illegal) clears the history flag.
  - Wrap: 5 -> 0 is legal.
- err_count saturates at 255. At most one increment per accepted pattern.
- Reset mid-filter: the partially counted candidate is discarded; after release the bus is re-evaluated from scratch.

Decomposition:
- Package seg7_pkg:
  - seg_t (logic [6:0]).
  - SEG_BLANK constant and the 16-entry hex glyph constant array.
  - Function seg_to_hex returning {valid, value}.
  - CHASE_LEN = 6.
- Sub-module seg7_debounce: synchroniser plus stability filter. Outputs the accepted pattern and the accept strobe.
- seg7_reader instantiates seg7_debounce and holds classification, chase history and err_count.

Test Plan:
- Reset, ACTIVE_LOW=1, seg_in=7'h7F -> all outputs 0; no new_pattern for 20 cycles.
- seg_in=~7'h30 held -> at edge 5 (STABLE_CYCLES=3): new_pattern=1 for one cycle, digit_valid=1, digit_out=1, pattern_out=7'h30.
- Drive the chase 3F,5F,6F,77,7B,7D,3F, each held 10 cycles -> chase_pos 0,1,2,3,4,5,0 with chase_valid=1; err_count stays 0.
- Chase 3F then 6F (skip) -> chase_pos=2, err_count=1. Then seg_in=~7'h01 (g only) -> err_count=2, both valid flags 0.
- 2-cycle pulse of ~7'h7F on a stable "1" -> no new_pattern; pattern_out stays 7'h30.
- Assert reset asynchronously mid-filter with err_count=255 saturated -> all outputs 0 immediately. Then 300 illegal patterns -> err_count stops at 255.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph tables for the 7-segment bus receiver.
// Pure declarations and a combinational decode helper; no state.
// No handshake; consumers use the helpers combinationally.
package seg7_pkg;

  // Segment vector, bit6=a ... bit1=f, bit0=g.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam int   CHASE_LEN = 6;

  // Active-high glyphs for hex values 0..F.
  localparam seg_t HEX_GLYPH [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  // Returns {valid, value}; value is 0 when the pattern is not a glyph.
  function automatic logic [4:0] seg_to_hex(input seg_t p);
    logic [4:0] r;
    r = 5'd0;
    for (int i = 0; i < 16; i++) begin
      if (p == HEX_GLYPH[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_debounce.sv
// Two-flop synchroniser plus stability filter for the raw segment bus.
// Accept strobe asserts STABLE_CYCLES edges after the pattern reaches the sync output.
// No backpressure; an accepted pattern is presented for one cycle on acc_*.
module seg7_debounce
  import seg7_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  seg_t seg_i,
  output seg_t pattern_o,
  output logic acc_stb_o,
  output seg_t acc_pat_o
);

  localparam seg_t       RAW_BLANK = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] STABLE    = 4'(STABLE_CYCLES);

  seg_t       sync1_q, sync2_q, cand_q, cand_d, pat_q, pat_d, norm;
  logic [3:0] cnt_q, cnt_d;
  logic       acc_stb;
  seg_t       acc_pat;

  assign norm = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Restart the count on any change; accept when the count would reach STABLE
  // and the stable value differs from what is already published.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    acc_stb = 1'b0;
    acc_pat = cand_q;
    if (norm != cand_q) begin
      cand_d  = norm;
      cnt_d   = 4'd1;
      acc_pat = norm;
      acc_stb = (STABLE == 4'd1) && (norm != pat_q);
    end else if (cnt_q < STABLE) begin
      cnt_d   = cnt_q + 4'd1;
      acc_stb = ((cnt_q + 4'd1) == STABLE) && (cand_q != pat_q);
    end
    pat_d = acc_stb ? acc_pat : pat_q;
  end

  // Synchroniser, candidate, counter and published pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= RAW_BLANK;
      sync2_q <= RAW_BLANK;
      cand_q  <= RAW_BLANK;
      cnt_q   <= 4'd0;
      pat_q   <= SEG_BLANK;
    end else begin
      sync1_q <= seg_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
    end
  end

  assign pattern_o = pat_q;
  assign acc_stb_o = acc_stb;
  assign acc_pat_o = acc_pat;

endmodule

// File: rtl/seg7_reader.sv
// Receives a 7-segment bus, classifies accepted patterns, checks chase order, counts errors.
// Outputs update 2+STABLE_CYCLES edges after seg_in settles.
// No backpressure; new_pattern is a one-cycle pulse per accepted change.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [6:0] pattern_out,
  output logic       new_pattern,
  output logic       digit_valid,
  output logic [3:0] digit_out,
  output logic       chase_valid,
  output logic [2:0] chase_pos,
  output logic [7:0] err_count
);

  seg_t acc_pat;
  logic acc_stb;

  seg7_debounce #(
    .ACTIVE_LOW   (ACTIVE_LOW),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .seg_i    (seg_in),
    .pattern_o(pattern_out),
    .acc_stb_o(acc_stb),
    .acc_pat_o(acc_pat)
  );

  logic       np_q, dv_q, dv_d, cv_q, cv_d, hist_q, hist_d;
  logic [3:0] dig_q, dig_d;
  logic [2:0] pos_q, pos_d, prev_q, prev_d, pos, exp_pos;
  logic [7:0] err_q, err_d;
  logic [4:0] hex;
  logic       is_chase, is_blank, err_inc;

  // Classify the pattern being accepted this cycle and compute next state.
  always_comb begin
    hex      = seg_to_hex(acc_pat);
    is_blank = (acc_pat == SEG_BLANK);
    is_chase = 1'b1;
    pos      = 3'd0;
    case (acc_pat)
      7'h40:   pos = 3'd0;
      7'h20:   pos = 3'd1;
      7'h10:   pos = 3'd2;
      7'h08:   pos = 3'd3;
      7'h04:   pos = 3'd4;
      7'h02:   pos = 3'd5;
      default: is_chase = 1'b0;
    endcase
    exp_pos = (prev_q == 3'(CHASE_LEN - 1)) ? 3'd0 : prev_q + 3'd1;
    err_inc = (!is_blank && !hex[4] && !is_chase) ||
              (is_chase && hist_q && (pos != exp_pos));
    dv_d   = dv_q;
    dig_d  = dig_q;
    cv_d   = cv_q;
    pos_d  = pos_q;
    hist_d = hist_q;
    prev_d = prev_q;
    err_d  = err_q;
    if (acc_stb) begin
      dv_d   = hex[4];
      dig_d  = hex[3:0];
      cv_d   = is_chase;
      pos_d  = pos;
      hist_d = is_chase;
      prev_d = is_chase ? pos : prev_q;
      if (err_inc && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end
  end

  // Classification, chase history and error counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      np_q   <= 1'b0;
      dv_q   <= 1'b0;
      dig_q  <= 4'd0;
      cv_q   <= 1'b0;
      pos_q  <= 3'd0;
      hist_q <= 1'b0;
      prev_q <= 3'd0;
      err_q  <= 8'd0;
    end else begin
      np_q   <= acc_stb;
      dv_q   <= dv_d;
      dig_q  <= dig_d;
      cv_q   <= cv_d;
      pos_q  <= pos_d;
      hist_q <= hist_d;
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign new_pattern = np_q;
  assign digit_valid = dv_q;
  assign digit_out   = dig_q;
  assign chase_valid = cv_q;
  assign chase_pos   = pos_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;

  logic       clk, reset;
  logic [6:0] seg_in;
  logic [6:0] pattern_out;
  logic       new_pattern, digit_valid, chase_valid;
  logic [3:0] digit_out;
  logic [2:0] chase_pos;
  logic [7:0] err_count;

  seg7_reader #(.ACTIVE_LOW(1'b1), .STABLE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in),
    .pattern_out(pattern_out), .new_pattern(new_pattern),
    .digit_valid(digit_valid), .digit_out(digit_out),
    .chase_valid(chase_valid), .chase_pos(chase_pos),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    int         np;
    logic [6:0] pat;
    logic       dv;
    logic [3:0] dig;
    logic       cv;
    logic [2:0] pos;
    logic [7:0] err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   np_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (new_pattern) np_cnt++;
  endtask

  task automatic add(input logic [6:0] seg, input int np, input logic [6:0] pat,
                     input logic dv, input logic [3:0] dig, input logic cv,
                     input logic [2:0] pos, input logic [7:0] err);
    vec_t v;
    v.seg = seg; v.np = np; v.pat = pat; v.dv = dv; v.dig = dig;
    v.cv = cv; v.pos = pos; v.err = err;
    vecs.push_back(v);
  endtask

  task automatic chk_all(input string tag, input logic [6:0] pat, input logic dv,
                         input logic [3:0] dig, input logic cv, input logic [2:0] pos,
                         input logic [7:0] err);
    chk({tag, ".pattern"}, 32'(pattern_out), 32'(pat));
    chk({tag, ".digit_valid"}, 32'(digit_valid), 32'(dv));
    chk({tag, ".digit_out"}, 32'(digit_out), 32'(dig));
    chk({tag, ".chase_valid"}, 32'(chase_valid), 32'(cv));
    chk({tag, ".chase_pos"}, 32'(chase_pos), 32'(pos));
    chk({tag, ".err_count"}, 32'(err_count), 32'(err));
  endtask

  // Hold an illegal pattern long enough to be accepted.
  task automatic drive_hold(input logic [6:0] seg, input int cycles);
    seg_in = seg;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  initial begin
    // raw (active-low) stimulus, expected normalised outputs
    add(7'h3F, 1, 7'h40, 0, 4'h0, 1, 3'd0, 8'd0);
    add(7'h5F, 1, 7'h20, 0, 4'h0, 1, 3'd1, 8'd0);
    add(7'h6F, 1, 7'h10, 0, 4'h0, 1, 3'd2, 8'd0);
    add(7'h77, 1, 7'h08, 0, 4'h0, 1, 3'd3, 8'd0);
    add(7'h7B, 1, 7'h04, 0, 4'h0, 1, 3'd4, 8'd0);
    add(7'h7D, 1, 7'h02, 0, 4'h0, 1, 3'd5, 8'd0);
    add(7'h3F, 1, 7'h40, 0, 4'h0, 1, 3'd0, 8'd0);
    add(7'h6F, 1, 7'h10, 0, 4'h0, 1, 3'd2, 8'd1);
    add(7'h7E, 1, 7'h01, 0, 4'h0, 0, 3'd0, 8'd2);
    add(7'h4F, 1, 7'h30, 1, 4'h1, 0, 3'd0, 8'd2);
    add(7'h01, 1, 7'h7E, 1, 4'h0, 0, 3'd0, 8'd2);
    add(7'h12, 1, 7'h6D, 1, 4'h2, 0, 3'd0, 8'd2);
    add(7'h4C, 1, 7'h33, 1, 4'h4, 0, 3'd0, 8'd2);
    add(7'h24, 1, 7'h5B, 1, 4'h5, 0, 3'd0, 8'd2);
    add(7'h00, 1, 7'h7F, 1, 4'h8, 0, 3'd0, 8'd2);
    add(7'h60, 1, 7'h1F, 1, 4'hB, 0, 3'd0, 8'd2);
    add(7'h38, 1, 7'h47, 1, 4'hF, 0, 3'd0, 8'd2);
    add(7'h7F, 1, 7'h00, 0, 4'h0, 0, 3'd0, 8'd2);
    add(7'h7F, 0, 7'h00, 0, 4'h0, 0, 3'd0, 8'd2);
    add(7'h7D, 1, 7'h02, 0, 4'h0, 1, 3'd5, 8'd2);
    add(7'h3F, 1, 7'h40, 0, 4'h0, 1, 3'd0, 8'd2);
    add(7'h7C, 1, 7'h03, 0, 4'h0, 0, 3'd0, 8'd3);
    add(7'h5F, 1, 7'h20, 0, 4'h0, 1, 3'd1, 8'd3);
    add(7'h4F, 1, 7'h30, 1, 4'h1, 0, 3'd0, 8'd3);

    // Reset state with a blank bus.
    reset  = 1'b1;
    seg_in = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst.new_pattern", 32'(new_pattern), 32'd0);
    chk_all("rst", 7'h00, 0, 4'h0, 0, 3'd0, 8'd0);
    reset  = 1'b0;
    np_cnt = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("idle.np_count", 32'(np_cnt), 32'd0);

    // First digit: pulse exactly on edge 5.
    seg_in = 7'h4F;
    np_cnt = 0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 4) chk("lat.e4_np", 32'(new_pattern), 32'd0);
      if (e == 5) begin
        chk("lat.e5_np", 32'(new_pattern), 32'd1);
        chk_all("lat.e5", 7'h30, 1, 4'h1, 0, 3'd0, 8'd0);
      end
      if (e == 6) chk("lat.e6_np", 32'(new_pattern), 32'd0);
    end
    for (int i = 0; i < 4; i++) tick();

    // Table-driven vectors, each held 10 cycles.
    foreach (vecs[i]) begin
      np_cnt = 0;
      seg_in = vecs[i].seg;
      for (int k = 0; k < 10; k++) tick();
      chk($sformatf("v%0d.np_count", i), 32'(np_cnt), 32'(vecs[i].np));
      chk_all($sformatf("v%0d", i), vecs[i].pat, vecs[i].dv, vecs[i].dig,
              vecs[i].cv, vecs[i].pos, vecs[i].err);
    end

    // Two-cycle glitch on a stable "1" is rejected.
    np_cnt = 0;
    seg_in = 7'h00;
    tick(); tick();
    seg_in = 7'h4F;
    for (int k = 0; k < 12; k++) tick();
    chk("glitch.np_count", 32'(np_cnt), 32'd0);
    chk("glitch.pattern", 32'(pattern_out), 32'h30);

    // Drive err_count from 3 to saturation, then one more.
    for (int i = 0; i < 252; i++) drive_hold((i % 2 == 0) ? 7'h7E : 7'h7C, 6);
    chk("sat.err_255", 32'(err_count), 32'd255);
    drive_hold(7'h7E, 6);
    chk("sat.err_hold", 32'(err_count), 32'd255);

    // Asynchronous reset mid-filter.
    seg_in = 7'h4F;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1;
    chk("arst.new_pattern", 32'(new_pattern), 32'd0);
    chk_all("arst", 7'h00, 0, 4'h0, 0, 3'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("arst.held_pattern", 32'(pattern_out), 32'h00);
    @(negedge clk);
    reset  = 1'b0;
    np_cnt = 0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e == 4) chk("rearm.e4_np", 32'(new_pattern), 32'd0);
      if (e == 5) begin
        chk("rearm.e5_np", 32'(new_pattern), 32'd1);
        chk_all("rearm.e5", 7'h30, 1, 4'h1, 0, 3'd0, 8'd0);
      end
    end

    // 300 illegal patterns: counts, then saturates.
    for (int i = 0; i < 300; i++) begin
      drive_hold((i % 2 == 0) ? 7'h7E : 7'h7C, 6);
      if (i == 9) chk("ill.err_10", 32'(err_count), 32'd10);
    end
    chk("ill.err_sat", 32'(err_count), 32'd255);
    chk("ill.digit_valid", 32'(digit_valid), 32'd0);
    chk("ill.chase_valid", 32'(chase_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
